// File: rtl/mdu_pkg.sv
// Shared constants and types for the multi-cycle multiply/divide unit.
// MDU_RADIX4_EN selects radix-4 Booth multiplication (16 iterations).
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

`ifdef MDU_RADIX4_EN
    localparam int MUL_ITERS = XLEN / 2;
`else
    localparam int MUL_ITERS = XLEN;
`endif
    localparam int DIV_ITERS = XLEN;

    // Divide by zero yields an all-ones quotient.
    localparam logic DIV_ZERO_QUO_BIT = 1'b1;

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between control and the multiply/divide unit.
// Master is the control unit; slave is mul_div_unit.
interface mdu_if #(
    parameter int WIDTH = 32
);

    logic             start;
    logic             op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_by_zero;

    modport master (
        output start, op, opa, opb,
        input  busy, done, result_hi, result_lo, div_by_zero
    );

    modport slave (
        input  start, op, opa, opb,
        output busy, done, result_hi, result_lo, div_by_zero
    );

endinterface

// File: rtl/mdu_booth_step.sv
// One Booth iteration: recode, add partial product, arithmetic shift.
// MDU_RADIX4_EN retires two multiplier bits per step instead of one.
module mdu_booth_step #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH+1:0] acc,
    input  logic        [WIDTH-1:0] q,
    input  logic                    qm1,
    input  logic        [WIDTH-1:0] m,
    output logic signed [WIDTH+1:0] acc_n,
    output logic        [WIDTH-1:0] q_n,
    output logic                    qm1_n
);

    logic signed [WIDTH+1:0] m_ext;
    logic signed [WIDTH+1:0] pp;
    logic signed [WIDTH+1:0] sum;

    // Two guard bits keep +/-2M exact for the most negative multiplicand.
    assign m_ext = {{2{m[WIDTH-1]}}, m};
    assign sum   = acc + pp;

`ifdef MDU_RADIX4_EN
    always_comb begin
        pp = '0;
        case ({q[1:0], qm1})
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext <<< 1;
            3'b100:         pp = -(m_ext <<< 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
    end

    assign acc_n = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
    assign q_n   = {sum[1:0], q[WIDTH-1:2]};
    assign qm1_n = q[1];
`else
    always_comb begin
        pp = '0;
        case ({q[0], qm1})
            2'b01:   pp = m_ext;
            2'b10:   pp = -m_ext;
            default: pp = '0;
        endcase
    end

    assign acc_n = {sum[WIDTH+1], sum[WIDTH+1:1]};
    assign q_n   = {sum[0], q[WIDTH-1:1]};
    assign qm1_n = q[0];
`endif

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (Booth) / divide (restoring) engine.
// MDU_RADIX4_EN switches the multiplier to radix-4 Booth.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input logic   clock,
    input logic   clear,
    mdu_if.slave  bus
);

    localparam int CNT_W = $clog2(DIV_ITERS + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic signed [WIDTH+1:0] acc;
    logic [WIDTH-1:0]        q;
    logic [WIDTH-1:0]        m;
    logic [WIDTH-1:0]        rem;
    logic                    qm1;
    logic                    a_neg;
    logic                    b_neg;
    logic                    b_zero;

    logic                    busy_q;
    logic                    done_q;
    logic [WIDTH-1:0]        hi_q;
    logic [WIDTH-1:0]        lo_q;
    logic                    dbz_q;

    logic signed [WIDTH+1:0] acc_n;
    logic [WIDTH-1:0]        q_n;
    logic                    qm1_n;

    logic [WIDTH-1:0]        a_mag;
    logic [WIDTH-1:0]        b_mag;
    logic [WIDTH:0]          shifted;
    logic [WIDTH:0]          trial;
    logic                    take;
    logic [WIDTH-1:0]        rem_n;
    logic [WIDTH-1:0]        quo_n;

    mdu_booth_step #(
        .WIDTH (WIDTH)
    ) u_booth (
        .acc   (acc),
        .q     (q),
        .qm1   (qm1),
        .m     (m),
        .acc_n (acc_n),
        .q_n   (q_n),
        .qm1_n (qm1_n)
    );

    assign a_mag = bus.opa[WIDTH-1] ? -bus.opa : bus.opa;
    assign b_mag = bus.opb[WIDTH-1] ? -bus.opb : bus.opb;

    // Dividend magnitude shifts out of q's MSB while quotient bits enter at the LSB.
    assign shifted = {rem, q[WIDTH-1]};
    assign trial   = shifted - {1'b0, m};
    assign take    = ~trial[WIDTH];
    assign rem_n   = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_n   = {q[WIDTH-2:0], take};

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            rem    <= '0;
            qm1    <= 1'b0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_zero <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        dbz_q  <= 1'b0;
                        cnt    <= '0;
                        acc    <= '0;
                        rem    <= '0;
                        qm1    <= 1'b0;
                        if (bus.op == OP_DIV) begin
                            state  <= S_DIV;
                            q      <= a_mag;
                            m      <= b_mag;
                            a_neg  <= bus.opa[WIDTH-1];
                            b_neg  <= bus.opb[WIDTH-1];
                            b_zero <= (bus.opb == '0);
                        end else begin
                            state <= S_MUL;
                            q     <= bus.opb;
                            m     <= bus.opa;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt == MUL_LAST) begin
                        hi_q   <= acc[WIDTH-1:0];
                        lo_q   <= q;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        acc <= acc_n;
                        q   <= q_n;
                        qm1 <= qm1_n;
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DIV: begin
                    if (b_zero) begin
                        if (cnt == CNT_ONE) begin
                            hi_q   <= a_neg ? -q : q;
                            lo_q   <= {WIDTH{DIV_ZERO_QUO_BIT}};
                            dbz_q  <= 1'b1;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else if (cnt == DIV_LAST) begin
                        state <= S_FIX;
                    end else begin
                        rem <= rem_n;
                        q   <= quo_n;
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_FIX: begin
                    // Truncating division: remainder follows the dividend's sign.
                    lo_q   <= (a_neg ^ b_neg) ? -q : q;
                    hi_q   <= a_neg ? -rem : rem;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result_hi   = hi_q;
    assign bus.result_lo   = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule
